// File: rtl/bf_data_port_if.sv
// Core data-side request bundle plus the two host byte streams of bf_data_port.
// master = core/host driver side, slave = the data port itself.
interface bf_data_port_if #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 16
);
    logic [AWIDTH-1:0] dp_adr;
    logic [DWIDTH-1:0] data_out;
    logic              data_w_req;
    logic              data_w_sel;
    logic              data_w_wait;
    logic              data_r_req;
    logic              data_r_sel;
    logic [DWIDTH-1:0] data_in;
    logic              data_den;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              ovf;
    logic              unf;

    modport master (
        output dp_adr, data_out, data_w_req, data_w_sel, data_r_req, data_r_sel,
        output tx_ready, rx_data, rx_valid,
        input  data_w_wait, data_in, data_den, tx_data, tx_valid, rx_ready, ovf, unf
    );

    modport slave (
        input  dp_adr, data_out, data_w_req, data_w_sel, data_r_req, data_r_sel,
        input  tx_ready, rx_data, rx_valid,
        output data_w_wait, data_in, data_den, tx_data, tx_valid, rx_ready, ovf, unf
    );
endinterface

// File: rtl/bf_data_port.sv
// Byte FIFO: 2^LOG2 entries, push refused when full, pop refused when empty.
// Latency: a pushed byte is visible at head the cycle after the push.
// Backpressure: full/empty come from the registered count only; no fall-through.
module bf_byte_fifo #(
    parameter int LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_vld,
    input  logic [7:0] push_dat,
    input  logic       pop_req,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);
    localparam int DEPTH = 2 ** LOG2;

    logic [7:0]      mem [DEPTH];
    logic [LOG2-1:0] wr_ptr;
    logic [LOG2-1:0] rd_ptr;
    logic [LOG2:0]   count;
    logic            push_acc;
    logic            pop_acc;

    assign full     = (count == (LOG2+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_acc = push_vld & ~full;
    assign pop_acc  = pop_req & ~empty;
    // Storage is never reset, so the head is forced to zero while empty.
    assign head     = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (LOG2+1)'(push_acc) - (LOG2+1)'(pop_acc);
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc && !rst) mem[wr_ptr] <= push_dat;
    end

    count_in_range: assert property (@(posedge clk) disable iff (rst)
        count <= (LOG2+1)'(DEPTH));
endmodule

// Data-side responder for the brainfuck core: data RAM, '.' output FIFO, ',' input FIFO.
// Latency: reads answer exactly one cycle after the request (registered data_in/data_den).
// Backpressure: none toward the core; full output pushes drop (ovf), empty pops underflow (unf).
module bf_data_port #(
    parameter int AWIDTH  = 12,
    parameter int DWIDTH  = 16,
    parameter int OF_LOG2 = 4,
    parameter int IF_LOG2 = 4
) (
    input logic          clk,
    input logic          rst,
    bf_data_port_if.slave dp
);
    logic ram_wr;
    logic out_push;
    logic ram_rd;
    logic in_pop;

    assign ram_wr   = dp.data_w_req & ~dp.data_w_sel;
    assign out_push = dp.data_w_req &  dp.data_w_sel;
    assign ram_rd   = dp.data_r_req & ~dp.data_r_sel;
    assign in_pop   = dp.data_r_req &  dp.data_r_sel;

    // Contents survive reset; the core clears them with its own init sweep.
    logic [DWIDTH-1:0] ram [2**AWIDTH];

    always_ff @(posedge clk) begin
        if (ram_wr && !rst) ram[dp.dp_adr] <= dp.data_out;
    end

    logic       out_full;
    logic       out_empty;
    logic [7:0] out_head;
    logic       in_full;
    logic       in_empty;
    logic [7:0] in_head;

    bf_byte_fifo #(.LOG2(OF_LOG2)) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (out_push),
        .push_dat (dp.data_out[7:0]),
        .pop_req  (dp.tx_ready),
        .head     (out_head),
        .full     (out_full),
        .empty    (out_empty)
    );

    bf_byte_fifo #(.LOG2(IF_LOG2)) u_in_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (dp.rx_valid),
        .push_dat (dp.rx_data),
        .pop_req  (in_pop),
        .head     (in_head),
        .full     (in_full),
        .empty    (in_empty)
    );

    assign dp.data_w_wait = out_full;
    assign dp.tx_valid    = ~out_empty;
    assign dp.tx_data     = out_head;
    assign dp.rx_ready    = ~in_full;

    // RAM read samples the pre-write word, giving read-first behaviour on a same-address write.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp.data_in  <= '0;
            dp.data_den <= 1'b0;
            dp.ovf      <= 1'b0;
            dp.unf      <= 1'b0;
        end else begin
            if (ram_rd) begin
                dp.data_in  <= ram[dp.dp_adr];
                dp.data_den <= 1'b1;
            end else if (in_pop && !in_empty) begin
                dp.data_in  <= DWIDTH'(in_head);
                dp.data_den <= 1'b1;
            end else if (in_pop) begin
                dp.data_in  <= '0;
                dp.data_den <= 1'b0;
                dp.unf      <= 1'b1;
            end else begin
                dp.data_den <= 1'b0;
            end
            if (out_push && out_full) dp.ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bf_data_port.sv
// Directed bench for bf_data_port: RAM, both FIFOs, boundaries, wrap and reset.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_bf_data_port;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    bf_data_port_if #(.AWIDTH(12), .DWIDTH(16)) dpi ();

    bf_data_port #(.AWIDTH(12), .DWIDTH(16), .OF_LOG2(4), .IF_LOG2(4)) dut (
        .clk (clk),
        .rst (rst),
        .dp  (dpi)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dpi.data_w_req = 1'b0;
        dpi.data_r_req = 1'b0;
        dpi.rx_valid   = 1'b0;
        dpi.tx_ready   = 1'b0;
    endtask

    task automatic ram_write(input logic [11:0] a, input logic [15:0] d);
        dpi.dp_adr = a; dpi.data_out = d;
        dpi.data_w_req = 1'b1; dpi.data_w_sel = 1'b0;
        dpi.data_r_req = 1'b0;
    endtask

    task automatic ram_read(input logic [11:0] a);
        dpi.dp_adr = a;
        dpi.data_w_req = 1'b0;
        dpi.data_r_req = 1'b1; dpi.data_r_sel = 1'b0;
    endtask

    task automatic in_pop();
        dpi.data_w_req = 1'b0;
        dpi.data_r_req = 1'b1; dpi.data_r_sel = 1'b1;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_data_in"},  32'(dpi.data_in), 32'h0);
        chk({pfx, "_den"},      32'(dpi.data_den), 32'h0);
        chk({pfx, "_tx_valid"}, 32'(dpi.tx_valid), 32'h0);
        chk({pfx, "_rx_ready"}, 32'(dpi.rx_ready), 32'h1);
        chk({pfx, "_w_wait"},   32'(dpi.data_w_wait), 32'h0);
        chk({pfx, "_ovf"},      32'(dpi.ovf), 32'h0);
        chk({pfx, "_unf"},      32'(dpi.unf), 32'h0);
        chk({pfx, "_tx_data"},  32'(dpi.tx_data), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q_tx[$];
        logic [7:0] q_rx[$];
        logic [31:0] exp;
        logic        pop_ok;
        int tx_sent, tx_got, rx_sent, rx_got;

        dpi.dp_adr = '0; dpi.data_out = '0;
        dpi.data_w_sel = 1'b0; dpi.data_r_sel = 1'b0;
        dpi.rx_data = '0;
        idle();

        // Reset state.
        rst = 1'b1;
        tick();
        chk_reset_vals("rst0");
        rst = 1'b0;

        // Core-style init sweep of the low addresses.
        for (int a = 0; a < 32; a++) begin
            ram_write(12'(a), 16'h0000);
            tick();
        end

        // Basic RAM write/read and hold behaviour.
        ram_write(12'h005, 16'h1234); tick();
        ram_read(12'h005);            tick();
        chk("ram_rd5", 32'(dpi.data_in), 32'h1234);
        chk("ram_rd5_den", 32'(dpi.data_den), 32'h1);
        ram_read(12'h006);            tick();
        chk("ram_rd6", 32'(dpi.data_in), 32'h0000);
        chk("ram_rd6_den", 32'(dpi.data_den), 32'h1);
        ram_read(12'h005);            tick();
        idle();                       tick();
        chk("hold_data", 32'(dpi.data_in), 32'h1234);
        chk("hold_den", 32'(dpi.data_den), 32'h0);

        // Read-first on a same-address read+write.
        ram_write(12'h010, 16'h0001); tick();
        ram_write(12'h010, 16'h0002);
        dpi.data_r_req = 1'b1; dpi.data_r_sel = 1'b0;
        tick();
        chk("rf_old", 32'(dpi.data_in), 32'h0001);
        ram_read(12'h010);            tick();
        chk("rf_new", 32'(dpi.data_in), 32'h0002);
        idle();

        // Output FIFO fill with tx_ready low, 17th push overflows.
        for (int i = 0; i < 17; i++) begin
            dpi.data_out = 16'hAB00 | 16'(8'h41 + i);
            dpi.data_w_req = 1'b1; dpi.data_w_sel = 1'b1;
            tick();
            if (i == 0)  chk("of_first_head", 32'(dpi.tx_data), 32'h41);
            if (i == 14) chk("of_wait15", 32'(dpi.data_w_wait), 32'h0);
            if (i == 15) chk("of_wait16", 32'(dpi.data_w_wait), 32'h1);
            if (i == 15) chk("of_ovf16", 32'(dpi.ovf), 32'h0);
        end
        chk("of_ovf17", 32'(dpi.ovf), 32'h1);
        dpi.data_w_req = 1'b0;
        dpi.tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("of_drain_vld", 32'(dpi.tx_valid), 32'h1);
            chk("of_drain_dat", 32'(dpi.tx_data), 32'(8'h41 + i));
            tick();
        end
        chk("of_empty", 32'(dpi.tx_valid), 32'h0);
        chk("of_ovf_sticky", 32'(dpi.ovf), 32'h1);
        idle();

        // Input FIFO order and underflow.
        dpi.rx_valid = 1'b1; dpi.rx_data = 8'h30; tick();
        dpi.rx_data = 8'h31;                      tick();
        dpi.rx_valid = 1'b0;
        in_pop(); tick();
        chk("if_pop0", 32'(dpi.data_in), 32'h0030);
        chk("if_pop0_den", 32'(dpi.data_den), 32'h1);
        chk("if_unf_clear", 32'(dpi.unf), 32'h0);
        tick();
        chk("if_pop1", 32'(dpi.data_in), 32'h0031);
        chk("if_pop1_den", 32'(dpi.data_den), 32'h1);
        tick();
        chk("if_unf_data", 32'(dpi.data_in), 32'h0000);
        chk("if_unf_den", 32'(dpi.data_den), 32'h0);
        chk("if_unf", 32'(dpi.unf), 32'h1);
        idle();

        // Input FIFO full boundary.
        for (int i = 0; i < 16; i++) begin
            dpi.rx_valid = 1'b1; dpi.rx_data = 8'(8'h60 + i);
            tick();
            if (i == 14) chk("if_rdy15", 32'(dpi.rx_ready), 32'h1);
        end
        chk("if_full_rdy", 32'(dpi.rx_ready), 32'h0);
        dpi.rx_data = 8'h99; in_pop(); tick();        // push refused, pop taken
        chk("if_fullpp_dat", 32'(dpi.data_in), 32'h0060);
        chk("if_fullpp_rdy", 32'(dpi.rx_ready), 32'h1);
        dpi.rx_data = 8'h9A; tick();                   // push+pop at 15 keeps 15
        chk("if_pp15_dat", 32'(dpi.data_in), 32'h0061);
        chk("if_pp15_rdy", 32'(dpi.rx_ready), 32'h1);
        dpi.data_r_req = 1'b0; dpi.rx_data = 8'h9B; tick();
        chk("if_refull_rdy", 32'(dpi.rx_ready), 32'h0);
        dpi.rx_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_pop(); tick();
            exp = (i < 14) ? 32'(8'h62 + i) : ((i == 14) ? 32'h9A : 32'h9B);
            chk("if_drain_dat", 32'(dpi.data_in), exp);
            chk("if_drain_den", 32'(dpi.data_den), 32'h1);
        end
        tick();
        chk("if_drain_end_den", 32'(dpi.data_den), 32'h0);
        idle();

        // Pointer wrap: 40 bytes through each FIFO concurrently.
        tx_sent = 0; tx_got = 0; rx_sent = 0; rx_got = 0;
        for (int cyc = 0; cyc < 2000 && (tx_got < 40 || rx_got < 40); cyc++) begin
            dpi.tx_ready   = 1'($urandom_range(0, 1));
            dpi.data_w_sel = 1'b1;
            dpi.data_w_req = (tx_sent < 40) && !dpi.data_w_wait;
            dpi.data_out   = 16'(8'(tx_sent * 7 + 3));
            chk("wrap_tx_vld", 32'(dpi.tx_valid), 32'(q_tx.size() != 0));
            if (dpi.tx_valid && dpi.tx_ready) begin
                exp = 32'hDEAD;
                if (q_tx.size() > 0) exp = 32'(q_tx.pop_front());
                chk("wrap_tx_dat", 32'(dpi.tx_data), exp);
                tx_got++;
            end
            if (dpi.data_w_req) begin
                q_tx.push_back(8'(tx_sent * 7 + 3));
                tx_sent++;
            end

            dpi.rx_valid   = (rx_sent < 40) && ($urandom_range(0, 1) == 1);
            dpi.rx_data    = 8'(rx_sent * 5 + 1);
            dpi.data_r_sel = 1'b1;
            dpi.data_r_req = (rx_got < 40) && ($urandom_range(0, 1) == 1);
            chk("wrap_rx_rdy", 32'(dpi.rx_ready), 32'(q_rx.size() != 16));
            pop_ok = dpi.data_r_req && (q_rx.size() > 0);
            exp = 32'h0;
            if (pop_ok) exp = 32'(q_rx.pop_front());
            if (dpi.rx_valid && dpi.rx_ready) begin
                q_rx.push_back(8'(rx_sent * 5 + 1));
                rx_sent++;
            end
            tick();
            chk("wrap_rx_den", 32'(dpi.data_den), 32'(pop_ok));
            if (pop_ok) begin
                chk("wrap_rx_dat", 32'(dpi.data_in), exp);
                rx_got++;
            end
        end
        chk("wrap_tx_count", 32'(tx_got), 32'd40);
        chk("wrap_rx_count", 32'(rx_got), 32'd40);
        idle();
        tick();

        // Reset mid-stream.
        ram_write(12'h01F, 16'hBEEF); tick();
        dpi.data_w_sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dpi.data_w_req = 1'b1; dpi.data_out = 16'(8'h70 + i);
            dpi.rx_valid = 1'b1;   dpi.rx_data = 8'(8'h80 + i);
            tick();
        end
        dpi.rx_valid = 1'b0;
        chk("pre_rst_tx_vld", 32'(dpi.tx_valid), 32'h1);
        ram_read(12'h01F); tick();
        chk("pre_rst_rd", 32'(dpi.data_in), 32'hBEEF);
        ram_write(12'h01F, 16'hDEAD);
        dpi.rx_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        chk_reset_vals("rst1");
        ram_read(12'h01F); tick();
        chk("post_rst_rd", 32'(dpi.data_in), 32'hBEEF);
        chk("post_rst_den", 32'(dpi.data_den), 32'h1);
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
